// File: rtl/branch_resolve_predictor.sv
// Branch predictor (ID) and resolver (EX) for the 5-stage pipeline.
// Holds a 2-bit saturating counter table plus its own ID->EX slot carrying the prediction.
module branch_resolve_predictor #(
  parameter int unsigned IDX_BITS   = 4,
  parameter logic [1:0]  INIT_STATE = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_branch_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_imm_i,
  input  logic        id_stall_i,
  input  logic        ex_zero_i,
  output logic        predict_taken_o,
  output logic [31:0] pred_target_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic                pred;
    logic [IDX_BITS-1:0] idx;
    logic [31:0]         target;
    logic [31:0]         fall;
  } slot_t;

  slot_t               slot;
  logic [1:0]          ctr_tbl [ENTRIES];
  logic [IDX_BITS-1:0] id_idx;
  logic [1:0]          ctr_cur;
  logic [1:0]          ctr_next;
  logic                mispredict;

  // ID: the read sees the pre-update table even when EX writes the same index.
  assign id_idx          = id_pc_i[IDX_BITS+1:2];
  assign predict_taken_o = id_branch_i & ctr_tbl[id_idx][1];
  assign pred_target_o   = id_pc_i + id_imm_i;

  // EX resolution
  assign mispredict    = slot.valid & (slot.pred != ex_zero_i);
  assign flush_o       = mispredict;
  assign redirect_pc_o = mispredict ? (ex_zero_i ? slot.target : slot.fall) : 32'h0;

  assign ctr_cur = ctr_tbl[slot.idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (ex_zero_i) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_tbl[i] <= INIT_STATE;
    end else if (slot.valid) begin
      ctr_tbl[slot.idx] <= ctr_next;
    end
  end

  // Slot load: a flush kills the wrong-path ID branch and wins over a stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot <= '0;
    end else if (flush_o || id_stall_i) begin
      slot.valid <= 1'b0;
    end else begin
      slot.valid  <= id_branch_i;
      slot.pred   <= predict_taken_o;
      slot.idx    <= id_idx;
      slot.target <= pred_target_o;
      slot.fall   <= id_pc_i + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o     <= 32'h0;
      mispredict_cnt_o <= 32'h0;
    end else if (slot.valid) begin
      if (branch_cnt_o != 32'hFFFF_FFFF) branch_cnt_o <= branch_cnt_o + 32'd1;
      if (mispredict && mispredict_cnt_o != 32'hFFFF_FFFF)
        mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_predictor.sv
// Scoreboard bench for branch_resolve_predictor: ID-time predictions are queued
// and compared against the EX-cycle flush/redirect outputs.
module tb_branch_resolve_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        id_branch_i = 1'b0;
  logic [31:0] id_pc_i = '0;
  logic [31:0] id_imm_i = '0;
  logic        id_stall_i = 1'b0;
  logic        ex_zero_i = 1'b0;
  logic        predict_taken_o;
  logic [31:0] pred_target_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  branch_resolve_predictor #(.IDX_BITS(4), .INIT_STATE(2'b11)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_branch_i(id_branch_i), .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
    .id_stall_i(id_stall_i), .ex_zero_i(ex_zero_i),
    .predict_taken_o(predict_taken_o), .pred_target_o(pred_target_o),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        pred;
    bit [31:0] target;
    bit [31:0] fall;
    int        idx;
  } exp_t;

  exp_t      sb[$];
  bit [1:0]  mdl [16];
  int        bcnt, mcnt;
  int        checks = 0;
  int        errors = 0;
  logic        last_pred, last_flush;
  logic [31:0] last_redir;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 2'b11;
    sb.delete();
    bcnt = 0;
    mcnt = 0;
  endfunction

  // One pipeline cycle: drive ID/EX inputs, check combinational outputs, clock, check stats.
  task automatic cycle(input bit br, input bit [31:0] pc, input bit [31:0] imm,
                       input bit stall, input bit zero);
    bit        exp_pred, exp_flush;
    bit [31:0] exp_redir;
    exp_t      e;
    id_branch_i = br; id_pc_i = pc; id_imm_i = imm; id_stall_i = stall; ex_zero_i = zero;
    #2;
    exp_pred = br && mdl[pc[5:2]][1];
    last_pred = predict_taken_o;
    checks++;
    if (predict_taken_o !== exp_pred) begin
      errors++;
      $display("FAIL predict pc=%h: got %b exp %b", pc, predict_taken_o, exp_pred);
    end
    if (br) begin
      checks++;
      if (pred_target_o !== pc + imm) begin
        errors++;
        $display("FAIL target pc=%h: got %h exp %h", pc, pred_target_o, pc + imm);
      end
    end
    exp_flush = 1'b0;
    exp_redir = 32'h0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.pred != zero) begin
        exp_flush = 1'b1;
        exp_redir = zero ? e.target : e.fall;
        mcnt++;
      end
      bcnt++;
      if (zero && mdl[e.idx] != 2'b11) mdl[e.idx] = mdl[e.idx] + 2'b01;
      if (!zero && mdl[e.idx] != 2'b00) mdl[e.idx] = mdl[e.idx] - 2'b01;
    end
    last_flush = flush_o;
    last_redir = redirect_pc_o;
    checks++;
    if (flush_o !== exp_flush || redirect_pc_o !== exp_redir) begin
      errors++;
      $display("FAIL resolve: got flush=%b redir=%h exp flush=%b redir=%h",
               flush_o, redirect_pc_o, exp_flush, exp_redir);
    end
    if (!exp_flush && !stall && br) begin
      e.pred = exp_pred; e.target = pc + imm; e.fall = pc + 32'd4; e.idx = int'(pc[5:2]);
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    checks++;
    if (branch_cnt_o !== 32'(bcnt) || mispredict_cnt_o !== 32'(mcnt)) begin
      errors++;
      $display("FAIL stats: got %0d/%0d exp %0d/%0d", branch_cnt_o, mispredict_cnt_o, bcnt, mcnt);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; id_branch_i = 1'b0; id_stall_i = 1'b0; ex_zero_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (flush_o !== 1'b0 || redirect_pc_o !== 32'h0 || branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got flush=%b redir=%h cnt=%0d/%0d exp 0", flush_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o);
    end
    cycle(1, 32'h40, 32'h10, 0, 0);
    checks++;
    if (last_pred !== 1'b1 || pred_target_o !== 32'h50) begin
      errors++;
      $display("FAIL reset_default_pred: got %b/%h exp 1/00000050", last_pred, pred_target_o);
    end
    cycle(0, 32'h0, 32'h0, 0, 1);
    checks++;
    if (last_flush !== 1'b0 || branch_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL reset_taken_resolve: got flush=%b cnt=%0d exp 0/1", last_flush, branch_cnt_o);
    end
  endtask

  task automatic test_mispredict();
    cycle(1, 32'h40, 32'h10, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 0);
    checks++;
    if (last_flush !== 1'b1 || last_redir !== 32'h44 || mispredict_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL mispredict_fall: got flush=%b redir=%h mcnt=%0d exp 1/00000044/1",
               last_flush, last_redir, mispredict_cnt_o);
    end
    // entry 0 is now weak-taken: still predicts taken
    cycle(1, 32'h40, 32'h10, 0, 0);
    checks++;
    if (last_pred !== 1'b1) begin
      errors++;
      $display("FAIL weak_taken_pred: got %b exp 1", last_pred);
    end
    cycle(0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_hysteresis();
    logic [2:0] preds;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h40, 32'h10, 0, 0);
      preds[2-i] = last_pred;
      cycle(0, 32'h0, 32'h0, 0, 0);
    end
    checks++;
    if (preds !== 3'b110) begin
      errors++;
      $display("FAIL hyst_nt_preds: got %b exp 110", preds);
    end
    cycle(1, 32'h40, 32'h10, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 1);
    checks++;
    if (last_flush !== 1'b1 || last_redir !== 32'h50) begin
      errors++;
      $display("FAIL hyst_taken_redirect: got %b/%h exp 1/00000050", last_flush, last_redir);
    end
    cycle(1, 32'h40, 32'h10, 0, 0);
    checks++;
    if (last_pred !== 1'b0) begin
      errors++;
      $display("FAIL hyst_weak_nt: got %b exp 0", last_pred);
    end
    cycle(0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_flush_beats_stall();
    logic [31:0] b0, m0;
    do_reset();
    cycle(1, 32'h40, 32'h10, 0, 0);
    cycle(1, 32'h84, 32'h8, 1, 0);
    checks++;
    if (last_flush !== 1'b1) begin
      errors++;
      $display("FAIL fbs_flush: got %b exp 1", last_flush);
    end
    b0 = branch_cnt_o; m0 = mispredict_cnt_o;
    cycle(0, 32'h0, 32'h0, 0, 1);
    checks++;
    if (last_flush !== 1'b0 || branch_cnt_o !== b0 || mispredict_cnt_o !== m0) begin
      errors++;
      $display("FAIL fbs_cleared: got flush=%b cnt=%0d/%0d exp 0/%0d/%0d", last_flush,
               branch_cnt_o, mispredict_cnt_o, b0, m0);
    end
  endtask

  task automatic test_alias_negative();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1, 32'h40, 32'h10, 0, 0);
      cycle(0, 32'h0, 32'h0, 0, 0);
    end
    cycle(1, 32'h80, 32'hFFFF_FFF0, 0, 0);
    checks++;
    if (last_pred !== 1'b0 || pred_target_o !== 32'h70) begin
      errors++;
      $display("FAIL alias_pred: got %b/%h exp 0/00000070", last_pred, pred_target_o);
    end
    cycle(0, 32'h0, 32'h0, 0, 1);
    checks++;
    if (last_flush !== 1'b1 || last_redir !== 32'h70) begin
      errors++;
      $display("FAIL alias_redirect: got %b/%h exp 1/00000070", last_flush, last_redir);
    end
  endtask

  task automatic test_stalled_branch();
    do_reset();
    cycle(1, 32'h48, 32'h20, 1, 0);
    cycle(1, 32'h48, 32'h20, 1, 0);
    cycle(1, 32'h48, 32'h20, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 0);
    checks++;
    if (branch_cnt_o !== 32'd1 || last_redir !== 32'h4C) begin
      errors++;
      $display("FAIL stall_once: got cnt=%0d redir=%h exp 1/0000004c", branch_cnt_o, last_redir);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 3) != 0), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
            {$urandom} & 32'hFFFF_FFFE, $urandom_range(0, 4) == 0, 1'($urandom));
    cycle(0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 32'h40, 32'h10, 0, 0);
    id_branch_i = 1'b0; ex_zero_i = 1'b0;
    #2;
    checks++;
    if (flush_o !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_flush: got %b exp 1", flush_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (flush_o !== 1'b0 || redirect_pc_o !== 32'h0 || branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got flush=%b redir=%h cnt=%0d/%0d exp 0", flush_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o);
    end
    for (int i = 0; i < 16; i++) begin
      id_branch_i = 1'b1; id_pc_i = 32'(i) << 2;
      #0.1;
      checks++;
      if (predict_taken_o !== 1'b1) begin
        errors++;
        $display("FAIL async_table idx=%0d: got %b exp 1", i, predict_taken_o);
      end
    end
    id_branch_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    cycle(1, 32'h40, 32'h10, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mispredict();
    test_hysteresis();
    test_flush_beats_stall();
    test_alias_negative();
    test_stalled_branch();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
